// File: rtl/fetch_stage_if.sv
// Bus between the Y86-64 fetch stage and its surroundings: program-load port,
// step/commit control from the PC-update stage, and the decoded instruction fields.
interface fetch_stage_if;
  // No valid/ready pair here. load_en and step_en are sampled at each rising edge.
  // A load always completes on its edge and suppresses any step on that same edge.
  // A step commits only while stat is AOK. The outputs are continuous and need no acknowledge.
  logic        load_en;
  logic [63:0] load_addr;
  logic [7:0]  load_data;
  logic        step_en;
  logic [63:0] new_pc;
  logic [63:0] pc;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [2:0]  stat;

  modport master (
    output load_en, load_addr, load_data, step_en, new_pc,
    input  pc, icode, ifun, rA, rB, valC, valP, stat
  );

  modport slave (
    input  load_en, load_addr, load_data, step_en, new_pc,
    output pc, icode, ifun, rA, rB, valC, valP, stat
  );
endinterface

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC register, byte-wide instruction memory with a load port,
// combinational instruction split, and a run/halt/fault FSM whose state is stat.
module fetch_stage #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);
  localparam int          AW    = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam logic [64:0] LIMIT = 65'(IMEM_BYTES);

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  logic [7:0]  r_imem [IMEM_BYTES];
  logic [63:0] r_pc;
  logic [2:0]  r_state;

  logic [7:0]  w_byte [10];
  logic [3:0]  w_icode;
  logic [3:0]  w_ifun;
  logic [3:0]  w_len;
  logic        w_need_regids;
  logic [63:0] w_valc;
  logic        w_invalid;
  logic [64:0] w_last_addr;
  logic        w_imem_error;
  logic        w_load_ok;

  // Byte addresses are formed in 65 bits so a PC near 2^64 reads as out of range, not wrapped.
  for (genvar k = 0; k < 10; k++) begin : g_rd
    logic [64:0] w_a;
    assign w_a       = {1'b0, r_pc} + 65'(k);
    assign w_byte[k] = (w_a < LIMIT) ? r_imem[w_a[AW-1:0]] : 8'h00;
  end

  assign w_icode = w_byte[0][7:4];
  assign w_ifun  = w_byte[0][3:0];

  always_comb begin
    w_len         = 4'd1;
    w_need_regids = 1'b0;
    w_valc        = 64'd0;
    case (w_icode)
      4'h2, 4'h6, 4'hA, 4'hB: begin
        w_len         = 4'd2;
        w_need_regids = 1'b1;
      end
      4'h3, 4'h4, 4'h5: begin
        w_len         = 4'd10;
        w_need_regids = 1'b1;
        w_valc        = {w_byte[9], w_byte[8], w_byte[7], w_byte[6],
                         w_byte[5], w_byte[4], w_byte[3], w_byte[2]};
      end
      4'h7, 4'h8: begin
        w_len  = 4'd9;
        w_valc = {w_byte[8], w_byte[7], w_byte[6], w_byte[5],
                  w_byte[4], w_byte[3], w_byte[2], w_byte[1]};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_invalid = 1'b1;
    case (w_icode)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: w_invalid = (w_ifun != 4'd0);
      4'h2, 4'h7:                                         w_invalid = (w_ifun > 4'd6);
      4'h6:                                               w_invalid = (w_ifun > 4'd3);
      default:                                            w_invalid = 1'b1;
    endcase
  end

  assign w_last_addr  = {1'b0, r_pc} + {61'd0, w_len} - 65'd1;
  assign w_imem_error = (w_last_addr >= LIMIT);
  assign w_load_ok    = bus.load_en && ({1'b0, bus.load_addr} < LIMIT);

  // Program memory is deliberately left out of reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_imem[bus.load_addr[AW-1:0]] <= bus.load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= 64'd0;
      r_state <= S_AOK;
    end else if (!bus.load_en && bus.step_en && (r_state == S_AOK)) begin
      if (w_imem_error) begin
        r_state <= S_ADR;
      end else if (w_invalid) begin
        r_state <= S_INS;
      end else if (w_icode == 4'h0) begin
        r_state <= S_HLT;
      end else begin
        r_pc <= bus.new_pc;
      end
    end
  end

  assign bus.pc    = r_pc;
  assign bus.stat  = r_state;
  assign bus.icode = w_icode;
  assign bus.ifun  = w_ifun;
  assign bus.rA    = w_need_regids ? w_byte[1][7:4] : 4'hF;
  assign bus.rB    = w_need_regids ? w_byte[1][3:0] : 4'hF;
  assign bus.valC  = w_valc;
  assign bus.valP  = r_pc + {60'd0, w_len};
endmodule
